fir_coef_reload_master: RTL and testbench
=========================================

Name: fir_coef_reload_master

Overview:
- AXI-Stream master that drives the coefficient reload and config channels of the `fir` block.
- Holds a local coefficient table of `C_NUM_TAPS` entries. Software or bench logic fills it through a simple write port.
- On `start`, streams every coefficient in index order with `tlast` on the final tap, then issues one config transaction so the filter adopts the new set.

Parameters:
- `C_NUM_TAPS`, 63, number of coefficients streamed per reload.
- `C_COEF_WIDTH`, 16, stored coefficient width (signed two's complement).
- `C_RELOAD_TDATA_WIDTH`, 24, reload stream width; must be ≥ `C_COEF_WIDTH`.
- `C_CONFIG_TDATA_WIDTH`, 8, config stream width.
- `C_ADDR_WIDTH`, 6, write-address width; must satisfy 2^`C_ADDR_WIDTH` ≥ `C_NUM_TAPS`.

Ports:
- `aclk`  in  1  clock; all logic on the rising edge.
- `areset`  in  1  synchronous reset, active-high.
- `coef_wr_en`  in  1  write strobe for the coefficient table.
- `coef_wr_addr`  in  `C_ADDR_WIDTH`  table index to write.
- `coef_wr_data`  in  `C_COEF_WIDTH`  coefficient value.
- `coef_wr_err`  out  1  one-cycle pulse when a write is rejected.
- `start`  in  1  request a reload; sampled only in IDLE.
- `busy`  out  1  high in every state other than IDLE.
- `done`  out  1  one-cycle pulse when the config handshake completes.
- `m_axis_reload_tvalid`  out  1  reload data valid.
- `m_axis_reload_tready`  in  1  reload data accepted.
- `m_axis_reload_tlast`  out  1  marks the last coefficient.
- `m_axis_reload_tdata`  out  `C_RELOAD_TDATA_WIDTH`  sign-extended coefficient.
- `m_axis_config_tvalid`  out  1  config valid.
- `m_axis_config_tready`  in  1  config accepted.
- `m_axis_config_tdata`  out  `C_CONFIG_TDATA_WIDTH`  constant 0.

Behaviour:
- **Reset** (`areset`=1 at an edge): state=IDLE, tap index=0, all outputs 0 on the following cycle. Coefficient table contents are NOT cleared.
  - Reset mid-stream or mid-config abandons the transfer immediately: `tvalid` drops without a `tlast`. The downstream FIR must also be reset.
- **State machine**: IDLE → STREAM → CONFIG → IDLE.
- **IDLE**:
  - `coef_wr_en` with `coef_wr_addr` < `C_NUM_TAPS` writes the table.
  - An out-of-range address is dropped and `coef_wr_err` pulses the next cycle.
  - `start`=1 sets index=0 and enters STREAM.
  - If `start` and `coef_wr_en` are high in the same cycle, the write completes first, so the new value is streamed.
- **STREAM**:
  - `m_axis_reload_tvalid`=1 from the cycle after `start` is sampled; `tdata` = sign-extended table[0] in that cycle.
  - All reload outputs are registered. `tdata`, `tlast` and `tvalid` stay stable while `tready`=0; no combinational path from `tready` to any output.
  - On a handshake (`tvalid`&&`tready`), the index increments and `tdata` updates to the next entry at the same edge. This sustains one coefficient per cycle under continuous `tready`.
  - `tlast`=1 exactly when index = `C_NUM_TAPS`-1.
  - Handshake with `tlast` → CONFIG. `tvalid` is 0 in the next cycle.
- **CONFIG**:
  - `m_axis_config_tvalid`=1 and `tdata`=0, held until `m_axis_config_tready`.
  - Config handshake → IDLE. `done` pulses 1 cycle in the cycle after the handshake; `busy` is 0 in that same cycle.
- **Restrictions while busy**:
  - `coef_wr_en` is rejected with a `coef_wr_err` pulse and the table is unchanged.
  - `start` is ignored (not queued).
- **Width rule**: `tdata` = {(`C_RELOAD_TDATA_WIDTH`-`C_COEF_WIDTH`) copies of coef MSB, coef}.
- **Minimum reload time** with `tready` held high: `C_NUM_TAPS`+1 cycles from `start` sample to config handshake, plus 1 cycle to `done`.
- **Back-to-back**: `start` may be reasserted in the `done` cycle (state is IDLE) and is accepted.

Test Plan:
- **Reset**: hold `areset` 3 cycles → all outputs 0.
  - Write table[k]=k for k=0..62, `start`, `tready`=1 → 63 beats, `tdata` 0x000000..0x00003E in order, `tlast` only on beat 63, config beat `tdata`=0x00, `done` pulse at cycle 65 after `start`.
- **Sign extension**: table[0]=0x8000, table[1]=0x7FFF → beats 0xFF8000, 0x007FFF.
- **Backpressure**: `tready` toggled 1,0,0,1 pattern and config `tready` delayed 5 cycles → `tdata` stable during stalls, no beat lost or duplicated, `busy` high throughout, `done` after config handshake.
- **Illegal access**:
  - Write addr 63 in IDLE → `coef_wr_err` pulse, table unchanged.
  - Write addr 5 during STREAM → `coef_wr_err` pulse, table[5] unchanged on the next reload.
  - `start` during STREAM → ignored.
- **Reset mid-stream** after beat 10 → `tvalid` 0 next cycle, no `tlast`, state IDLE. A subsequent `start` streams from table[0] with preserved contents.
- **Same-cycle events**: `start` and write table[0]=0x1234 in the same IDLE cycle → first beat 0x001234. `start` in the `done` cycle → second reload begins next cycle.

Source files
------------

// File: rtl/fir_coef_reload_master.sv
// fir_coef_reload_master: AXI-Stream master that reloads the coefficients of the fir block.
// It keeps a local table of C_NUM_TAPS signed coefficients, which are written through
// coef_wr_*. On start it streams the whole table in index order on m_axis_reload_*,
// sign-extending each entry and raising tlast on the final tap. It then issues one
// all-zero config beat on m_axis_config_* so that the filter adopts the new set.
// Ports:
//   aclk, areset            clock and synchronous active-high reset
//   coef_wr_en/addr/data    table write port, accepted only while idle and in range
//   coef_wr_err             one-cycle pulse when a write is rejected
//   start, busy, done       reload request, in-progress flag, completion pulse
//   m_axis_reload_*         coefficient stream (tvalid/tready/tlast/tdata)
//   m_axis_config_*         config stream (tvalid/tready/tdata, data always zero)
module fir_coef_reload_master #(
  parameter int unsigned C_NUM_TAPS           = 63,
  parameter int unsigned C_COEF_WIDTH         = 16,
  parameter int unsigned C_RELOAD_TDATA_WIDTH = 24,
  parameter int unsigned C_CONFIG_TDATA_WIDTH = 8,
  parameter int unsigned C_ADDR_WIDTH         = 6
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            coef_wr_en,
  input  logic [C_ADDR_WIDTH-1:0]         coef_wr_addr,
  input  logic [C_COEF_WIDTH-1:0]         coef_wr_data,
  output logic                            coef_wr_err,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            m_axis_reload_tvalid,
  input  logic                            m_axis_reload_tready,
  output logic                            m_axis_reload_tlast,
  output logic [C_RELOAD_TDATA_WIDTH-1:0] m_axis_reload_tdata,
  output logic                            m_axis_config_tvalid,
  input  logic                            m_axis_config_tready,
  output logic [C_CONFIG_TDATA_WIDTH-1:0] m_axis_config_tdata
);

  localparam logic [C_ADDR_WIDTH:0]   NUM_TAPS = (C_ADDR_WIDTH+1)'(C_NUM_TAPS);
  localparam logic [C_ADDR_WIDTH-1:0] LAST_IDX = C_ADDR_WIDTH'(C_NUM_TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_CONFIG
  } state_t;

  state_t                  state;
  logic [C_ADDR_WIDTH-1:0] idx;
  logic [C_ADDR_WIDTH-1:0] idx_next;
  logic [C_COEF_WIDTH-1:0] coef_mem [C_NUM_TAPS];
  logic                    wr_ok;
  logic [C_COEF_WIDTH-1:0] first_coef;

  // Sign extension of a stored coefficient to the reload stream width.
  function automatic logic [C_RELOAD_TDATA_WIDTH-1:0] sext(input logic [C_COEF_WIDTH-1:0] c);
    return C_RELOAD_TDATA_WIDTH'($signed(c));
  endfunction

  // The table is writable only while idle and only for existing taps.
  assign wr_ok    = coef_wr_en && (state == S_IDLE) && ({1'b0, coef_wr_addr} < NUM_TAPS);
  assign idx_next = idx + C_ADDR_WIDTH'(1);

  // A write to tap 0 in the start cycle must be seen by the first beat, so bypass the table.
  assign first_coef = (wr_ok && (coef_wr_addr == '0)) ? coef_wr_data : coef_mem[0];

  // The config payload carries no information; the fir only needs the beat itself.
  assign m_axis_config_tdata = '0;

  // Coefficient table, deliberately not cleared by reset.
  always_ff @(posedge aclk) begin
    if (!areset && wr_ok) begin
      coef_mem[coef_wr_addr] <= coef_wr_data;
    end
  end

  // Reload sequencer: IDLE -> STREAM -> CONFIG -> IDLE, all outputs registered.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state                <= S_IDLE;
      idx                  <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      coef_wr_err          <= 1'b0;
      m_axis_reload_tvalid <= 1'b0;
      m_axis_reload_tlast  <= 1'b0;
      m_axis_reload_tdata  <= '0;
      m_axis_config_tvalid <= 1'b0;
    end else begin
      done        <= 1'b0;
      coef_wr_err <= coef_wr_en && !wr_ok;
      case (state)
        S_IDLE: begin
          if (start) begin
            state                <= S_STREAM;
            idx                  <= '0;
            busy                 <= 1'b1;
            m_axis_reload_tvalid <= 1'b1;
            m_axis_reload_tdata  <= sext(first_coef);
            m_axis_reload_tlast  <= (LAST_IDX == '0);
          end
        end
        S_STREAM: begin
          // Load the next tap on the same edge as the handshake for one beat per cycle.
          if (m_axis_reload_tready) begin
            if (m_axis_reload_tlast) begin
              state                <= S_CONFIG;
              m_axis_reload_tvalid <= 1'b0;
              m_axis_reload_tlast  <= 1'b0;
              m_axis_reload_tdata  <= '0;
              m_axis_config_tvalid <= 1'b1;
            end else begin
              idx                 <= idx_next;
              m_axis_reload_tdata <= sext(coef_mem[idx_next]);
              m_axis_reload_tlast <= (idx_next == LAST_IDX);
            end
          end
        end
        S_CONFIG: begin
          if (m_axis_config_tready) begin
            state                <= S_IDLE;
            m_axis_config_tvalid <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_reload_master.sv
// tb_fir_coef_reload_master: self-checking bench for fir_coef_reload_master.
// A transaction-level model (a table, a snapshot taken when a reload starts, a beat counter)
// predicts every output each cycle. Directed scenarios pin the model against hand-computed values.
module tb_fir_coef_reload_master;

  localparam int N  = 63;
  localparam int CW = 16;
  localparam int RW = 24;
  localparam int GW = 8;
  localparam int AW = 6;

  logic          aclk = 1'b0;
  logic          areset;
  logic          coef_wr_en;
  logic [AW-1:0] coef_wr_addr;
  logic [CW-1:0] coef_wr_data;
  logic          coef_wr_err;
  logic          start;
  logic          busy;
  logic          done;
  logic          m_axis_reload_tvalid;
  logic          m_axis_reload_tready;
  logic          m_axis_reload_tlast;
  logic [RW-1:0] m_axis_reload_tdata;
  logic          m_axis_config_tvalid;
  logic          m_axis_config_tready;
  logic [GW-1:0] m_axis_config_tdata;

  fir_coef_reload_master dut (
    .aclk                 (aclk),
    .areset               (areset),
    .coef_wr_en           (coef_wr_en),
    .coef_wr_addr         (coef_wr_addr),
    .coef_wr_data         (coef_wr_data),
    .coef_wr_err          (coef_wr_err),
    .start                (start),
    .busy                 (busy),
    .done                 (done),
    .m_axis_reload_tvalid (m_axis_reload_tvalid),
    .m_axis_reload_tready (m_axis_reload_tready),
    .m_axis_reload_tlast  (m_axis_reload_tlast),
    .m_axis_reload_tdata  (m_axis_reload_tdata),
    .m_axis_config_tvalid (m_axis_config_tvalid),
    .m_axis_config_tready (m_axis_config_tready),
    .m_axis_config_tdata  (m_axis_config_tdata)
  );

  always #5 aclk = ~aclk;

  int vec  = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] ext(input logic [CW-1:0] c);
    return {{(RW-CW){c[CW-1]}}, c};
  endfunction

  // Reference model: phase 0 idle, 1 streaming, 2 config.
  bit            m_live = 1'b0;
  int            m_phase = 0;
  int            m_k = 0;
  bit            m_done = 1'b0;
  bit            m_err = 1'b0;
  logic [CW-1:0] m_tbl  [N];
  logic [CW-1:0] m_snap [N];
  logic [RW:0]   got_q  [$];

  // Inputs change just after the rising edge, so at the falling edge they equal what the next edge samples.
  always @(negedge aclk) begin
    if (m_live) begin
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("done", 32'(done), 32'(m_done));
      chk("wr_err", 32'(coef_wr_err), 32'(m_err));
      chk("reload_tvalid", 32'(m_axis_reload_tvalid), 32'(m_phase == 1));
      chk("config_tvalid", 32'(m_axis_config_tvalid), 32'(m_phase == 2));
      chk("config_tdata", 32'(m_axis_config_tdata), 32'(0));
      if (m_phase == 1) begin
        chk("reload_tdata", 32'(m_axis_reload_tdata), 32'(ext(m_snap[m_k])));
        chk("reload_tlast", 32'(m_axis_reload_tlast), 32'(m_k == N-1));
      end else begin
        chk("reload_tlast_idle", 32'(m_axis_reload_tlast), 32'(0));
      end
      if (m_axis_reload_tvalid && m_axis_reload_tready && !areset)
        got_q.push_back({m_axis_reload_tlast, m_axis_reload_tdata});
    end
    if (areset) begin
      m_phase = 0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_live  = 1'b1;
    end else if (m_live) begin
      m_done = 1'b0;
      m_err  = coef_wr_en && (m_phase != 0 || int'(coef_wr_addr) >= N);
      if (m_phase == 0 && coef_wr_en && int'(coef_wr_addr) < N)
        m_tbl[coef_wr_addr] = coef_wr_data;
      case (m_phase)
        0: if (start) begin
          m_snap  = m_tbl;
          m_k     = 0;
          m_phase = 1;
        end
        1: if (m_axis_reload_tready) begin
          if (m_k == N-1) m_phase = 2;
          else m_k++;
        end
        2: if (m_axis_config_tready) begin
          m_phase = 0;
          m_done  = 1'b1;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Driver policy: bp_mode 0 = tready held high, 1 = 1,0,0,1 pattern, 2 = random.
  int bp_mode   = 0;
  int pat_i     = 0;
  int cfg_delay = 0;
  int cfg_wait  = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic step();
    @(posedge aclk);
    #1;
    start      = 1'b0;
    coef_wr_en = 1'b0;
    case (bp_mode)
      1:       begin m_axis_reload_tready = pat[pat_i % 4]; pat_i++; end
      2:       m_axis_reload_tready = 1'($urandom_range(0, 1));
      default: m_axis_reload_tready = 1'b1;
    endcase
    if (m_axis_config_tvalid) begin
      m_axis_config_tready = (cfg_wait >= cfg_delay);
      cfg_wait++;
    end else begin
      m_axis_config_tready = 1'b0;
      cfg_wait = 0;
    end
  endtask

  task automatic wr(input int a, input logic [CW-1:0] d);
    coef_wr_en   = 1'b1;
    coef_wr_addr = AW'(a);
    coef_wr_data = d;
    step();
  endtask

  // Returns the number of edges from the start sample up to the cycle showing done.
  task automatic wait_done(input int budget, output int steps);
    steps = 0;
    while (!done && steps < budget) begin
      step();
      steps++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'(1));
  endtask

  task automatic do_reload(output int lat);
    int n;
    got_q.delete();
    start = 1'b1;
    step();
    wait_done(3000, n);
    lat = n + 1;
  endtask

  initial begin
    int lat;
    int n;
    areset = 1'b1; coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
    start = 1'b0; m_axis_reload_tready = 1'b1; m_axis_config_tready = 1'b0;

    // Reset held for three cycles: every output low.
    repeat (3) step();
    chk("rst_tvalid", 32'(m_axis_reload_tvalid), 32'(0));
    chk("rst_tlast", 32'(m_axis_reload_tlast), 32'(0));
    chk("rst_tdata", 32'(m_axis_reload_tdata), 32'(0));
    chk("rst_cfg_tvalid", 32'(m_axis_config_tvalid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_wr_err", 32'(coef_wr_err), 32'(0));
    areset = 1'b0;
    step();

    // Ramp table, full-rate reload.
    for (int k = 0; k < N; k++) wr(k, CW'(k));
    do_reload(lat);
    chk("ramp_beats", 32'(got_q.size()), 32'(63));
    chk("ramp_latency", 32'(lat), 32'(65));
    for (int i = 0; i < got_q.size(); i++) begin
      chk("ramp_data", 32'(got_q[i][RW-1:0]), 32'(i));
      chk("ramp_last", 32'(got_q[i][RW]), 32'(i == 62));
    end

    // Sign extension.
    wr(0, 16'h8000);
    wr(1, 16'h7FFF);
    do_reload(lat);
    chk("sext_beat0", 32'(got_q[0][RW-1:0]), 32'h00FF8000);
    chk("sext_beat1", 32'(got_q[1][RW-1:0]), 32'h00007FFF);

    // Backpressure with illegal write and start while streaming.
    bp_mode = 1; pat_i = 0; cfg_delay = 5;
    got_q.delete();
    start = 1'b1;
    step();
    repeat (4) step();
    wr(5, 16'hBEEF);
    start = 1'b1;
    step();
    wait_done(3000, n);
    chk("bp_beats", 32'(got_q.size()), 32'(63));
    for (int i = 0; i < got_q.size(); i++)
      chk("bp_data", 32'(got_q[i][RW-1:0]), 32'(ext(m_tbl[i])));
    bp_mode = 0; cfg_delay = 0;
    wr(63, 16'hDEAD);
    step();
    do_reload(lat);
    chk("tap5_kept", 32'(got_q[5][RW-1:0]), 32'h00000005);
    chk("tap62_kept", 32'(got_q[62][RW-1:0]), 32'h0000003E);

    // Reset after ten beats.
    got_q.delete();
    start = 1'b1;
    step();
    n = 0;
    while (got_q.size() < 10 && n < 200) begin step(); n++; end
    m_axis_reload_tready = 1'b0;
    areset = 1'b1;
    step();
    areset = 1'b0;
    m_axis_reload_tready = 1'b1;
    chk("midrst_tvalid", 32'(m_axis_reload_tvalid), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_beats", 32'(got_q.size()), 32'(10));
    for (int i = 0; i < got_q.size(); i++) chk("midrst_no_last", 32'(got_q[i][RW]), 32'(0));
    do_reload(lat);
    chk("post_rst_beat0", 32'(got_q[0][RW-1:0]), 32'h00FF8000);

    // Write and start in the same cycle, then start again in the done cycle.
    got_q.delete();
    coef_wr_en = 1'b1; coef_wr_addr = '0; coef_wr_data = 16'h1234; start = 1'b1;
    step();
    wait_done(3000, n);
    chk("same_cycle_beat0", 32'(got_q[0][RW-1:0]), 32'h00001234);
    got_q.delete();
    start = 1'b1;
    step();
    chk("b2b_busy", 32'(busy), 32'(1));
    chk("b2b_tvalid", 32'(m_axis_reload_tvalid), 32'(1));
    wait_done(3000, n);
    chk("b2b_beats", 32'(got_q.size()), 32'(63));

    // Random traffic: writes, starts, backpressure and occasional resets.
    bp_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) cfg_delay = $urandom_range(0, 4);
      coef_wr_en   = ($urandom_range(0, 3) == 0);
      coef_wr_addr = AW'($urandom_range(0, 63));
      coef_wr_data = CW'($urandom);
      start        = ($urandom_range(0, 15) == 0);
      areset       = ($urandom_range(0, 600) == 0);
      step();
    end
    areset = 1'b0;
    bp_mode = 0;
    n = 0;
    while (busy && n < 500) begin step(); n++; end
    chk("final_idle", 32'(busy), 32'(0));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
